baud_tick_gen: RTL

Programmable fractional baud-rate generator, successor to the fixed-divisor tick counter. Produces an oversample tick, a bit tick and a mid-bit tick from one clock. The divisor is runtime-loadable with glitch-free switching on bit boundaries, and a Sync input realigns phase for the XBee UART RX start-bit. Feeds both the UART TX and RX engines.

---
 rtl/baud_pkg.sv | 30 +++
 rtl/frac_period_div.sv | 67 ++++++
 rtl/baud_tick_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared constants and divisor helper for the baud tick generator
//
// Purpose: default widths, minimum divisor and standard UART divisor settings
//          for a 100 MHz clock with 16x oversampling.
// Ports:   none (package).

package baud_pkg;

   localparam int DIV_W_DEF  = 16;
   localparam int FRAC_W_DEF = 4;
   localparam int OSR_DEF    = 16;

   // Smallest integer divisor the period counter can honour.
   localparam int MIN_DIV = 2;

   // {int, frac} divisors for 100 MHz / (rate * 16), frac in 1/16 cycle.
   localparam int DIV_9600_INT    = 651;
   localparam int DIV_9600_FRAC   = 1;
   localparam int DIV_19200_INT   = 325;
   localparam int DIV_19200_FRAC  = 8;
   localparam int DIV_57600_INT   = 108;
   localparam int DIV_57600_FRAC  = 8;
   localparam int DIV_115200_INT  = 54;
   localparam int DIV_115200_FRAC = 4;

   function automatic int unsigned clamp_div(input int unsigned v);
      return (v < int'(MIN_DIV)) ? int'(MIN_DIV) : v;
   endfunction

endpackage

// File: rtl/frac_period_div.sv
// rtl/frac_period_div.sv - fractional period counter producing the oversample tick
//
// Purpose: counts periods of Div_Int or Div_Int+1 cycles, the extra cycle taken
//          whenever the fractional accumulator carries, so the mean period is
//          Div_Int + Div_Frac/2^FRAC_W.
// Ports:   Clk, Reset_n   clock, synchronous active-low reset
//          Enable         1 = count, 0 = hold
//          Restart        clear count and accumulator (phase realign)
//          Div_Int/Frac   divisor sampled at each period start
//          Tick_Due       combinational: a tick is being registered this edge
//          Os_Tick        registered one-cycle pulse at the end of each period

module frac_period_div
   import baud_pkg::*;
#(
   parameter int DIV_W  = DIV_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Enable,
   input  logic              Restart,
   input  logic [DIV_W-1:0]  Div_Int,
   input  logic [FRAC_W-1:0] Div_Frac,
   output logic              Tick_Due,
   output logic              Os_Tick
);

   logic [DIV_W-1:0]  cnt;
   logic [DIV_W-1:0]  last;
   logic [FRAC_W-1:0] frac_acc;
   logic [FRAC_W:0]   frac_sum;

   assign frac_sum = {1'b0, frac_acc} + {1'b0, Div_Frac};

   // cnt==0 is always the period-start cycle; Div_Int>=2 guarantees it never
   // coincides with the final cycle, so a stale 'last' there is harmless.
   assign Tick_Due = Enable && !Restart && (cnt != '0) && (cnt == last);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         cnt      <= '0;
         last     <= '0;
         frac_acc <= '0;
         Os_Tick  <= 1'b0;
      end else if (Restart) begin
         cnt      <= '0;
         frac_acc <= '0;
         Os_Tick  <= 1'b0;
      end else if (!Enable) begin
         Os_Tick  <= 1'b0;
      end else begin
         Os_Tick <= Tick_Due;
         if (cnt == '0) begin
            // Period length is Div_Int plus the accumulator carry; store P-1.
            cnt      <= DIV_W'(1);
            last     <= Div_Int + DIV_W'(frac_sum[FRAC_W]) - DIV_W'(1);
            frac_acc <= frac_sum[FRAC_W-1:0];
         end else if (cnt == last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - programmable fractional baud generator with bit/mid-bit ticks
//
// Purpose: oversample, bit and mid-bit ticks for the UART TX/RX engines, with a
//          runtime divisor that switches only on bit boundaries and a Sync
//          input that realigns phase to an RX start-bit edge.
// Ports:   Clk, Reset_n              clock, synchronous active-low reset
//          Enable                    run / hold
//          Sync                      one-cycle phase restart
//          Div_Load, Div_Int_In,
//          Div_Frac_In               divisor load strobe and value
//          Os_Tick, Bit_Tick,
//          Mid_Tick                  registered tick pulses
//          Div_Pending               a loaded divisor awaits the next bit boundary

module baud_tick_gen
   import baud_pkg::*;
#(
   parameter int DIV_W    = DIV_W_DEF,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter int OSR      = OSR_DEF,
   parameter int DEF_INT  = DIV_9600_INT,
   parameter int DEF_FRAC = DIV_9600_FRAC
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Enable,
   input  logic              Sync,
   input  logic              Div_Load,
   input  logic [DIV_W-1:0]  Div_Int_In,
   input  logic [FRAC_W-1:0] Div_Frac_In,
   output logic              Os_Tick,
   output logic              Bit_Tick,
   output logic              Mid_Tick,
   output logic              Div_Pending
);

   localparam int PH_W = $clog2(OSR);

   logic [DIV_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   logic [DIV_W-1:0]  shd_int;
   logic [FRAC_W-1:0] shd_frac;
   logic [PH_W-1:0]   phase;
   logic              tick_due;
   logic              apply_shadow;
   logic [DIV_W-1:0]  load_int;
   logic [DIV_W-1:0]  use_int;
   logic [FRAC_W-1:0] use_frac;

   assign load_int = DIV_W'(clamp_div(32'(Div_Int_In)));

   // The cycle after Bit_Tick is the next period start; feeding the shadow
   // straight through lets that period already run at the new rate.
   assign apply_shadow = Div_Pending && (Bit_Tick || Sync);
   assign use_int      = apply_shadow ? shd_int  : act_int;
   assign use_frac     = apply_shadow ? shd_frac : act_frac;

   frac_period_div #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W)
   ) u_div (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Enable   (Enable),
      .Restart  (Sync),
      .Div_Int  (use_int),
      .Div_Frac (use_frac),
      .Tick_Due (tick_due),
      .Os_Tick  (Os_Tick)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         act_int     <= DIV_W'(DEF_INT);
         act_frac    <= FRAC_W'(DEF_FRAC);
         shd_int     <= '0;
         shd_frac    <= '0;
         Div_Pending <= 1'b0;
         phase       <= '0;
         Bit_Tick    <= 1'b0;
         Mid_Tick    <= 1'b0;
      end else begin
         if (apply_shadow) begin
            act_int     <= shd_int;
            act_frac    <= shd_frac;
            Div_Pending <= 1'b0;
         end
         // A load in the apply cycle is a fresh request: it wins the shadow.
         if (Div_Load) begin
            if (Enable) begin
               shd_int     <= load_int;
               shd_frac    <= Div_Frac_In;
               Div_Pending <= 1'b1;
            end else begin
               act_int     <= load_int;
               act_frac    <= Div_Frac_In;
               Div_Pending <= 1'b0;
            end
         end

         if (Sync) begin
            phase    <= '0;
            Bit_Tick <= 1'b0;
            Mid_Tick <= 1'b0;
         end else if (tick_due) begin
            phase    <= (phase == PH_W'(OSR - 1)) ? '0 : phase + PH_W'(1);
            Bit_Tick <= (phase == PH_W'(OSR - 1));
            Mid_Tick <= (phase == PH_W'(OSR / 2 - 1));
         end else begin
            Bit_Tick <= 1'b0;
            Mid_Tick <= 1'b0;
         end
      end
   end

endmodule
